xs3_digit_sequencer: RTL and testbench
======================================

Name: xs3_digit_sequencer

Overview:
- Converts a packed multi-digit word to excess-3, one 4-bit digit per clock, through a single shared "+3" digit converter.
- Sits between a producer and a consumer, each with a valid/ready handshake.
- Sequences the digit index, checks each digit's range, collects per-digit error flags and holds the result until the consumer takes it.

Parameters:
- DIGITS, 4, number of 4-bit digits per word (must be ≥ 1).
- BCD_CHECK, 1, range mode. 1: digits > 9 are invalid (strict BCD). 0: digits ≥ 13 are invalid (full converter range).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word.
- in_data  input  4*DIGITS  packed digits; digit i is in_data[4i+3:4i].
- out_valid  output  1  out_data, err_mask and out_err are valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  4*DIGITS  excess-3 result; digit i is at [4i+3:4i].
- err_mask  output  DIGITS  bit i set means digit i was out of range.
- out_err  output  1  OR-reduction of err_mask.
- busy  output  1  high in CONV or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, digit index=0, capture register=0, out_data=0, err_mask=0, out_err=0, out_valid=0, busy=0. in_ready=1 once reset is released.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture in_data, clear the result register and err_mask, set index=0, go to CONV.
- CONV:
  - in_ready=0, out_valid=0.
  - Each cycle, convert digit[index] (LSB digit first) through the single shared converter.
  - Valid digit: result digit = digit + 3, 4-bit; no overflow is possible within the valid range.
  - Invalid digit: result digit = 4'h0 and err_mask[index]=1.
  - Index increments each cycle. On the edge where index == DIGITS-1 is processed, go to DONE.
- DONE:
  - out_valid=1. out_data, err_mask and out_err are held stable.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - Result registers keep their last value after the transfer.
- Latency: out_valid rises exactly DIGITS cycles after the input-accept edge.
  - With out_ready held high, back-to-back throughput is one word per DIGITS+2 cycles.
  - No overlap: a new word is never accepted while in CONV or DONE.
- out_valid and in_ready are never high together.
- Both are decoded from state only, with no combinational path from the inputs.
- Boundary rules:
  - in_valid=1 outside IDLE is ignored; in_data is not sampled.
  - out_ready=1 outside DONE is ignored.
  - The index wraps to 0 on leaving CONV. The index width is clog2(DIGITS), minimum 1.
  - DIGITS=1: exactly one CONV cycle.
  - Strict mode (BCD_CHECK=1): digits 10–15 set the error bit.
  - Range mode (BCD_CHECK=0): digits 10–12 convert to D–F; only 13–15 set the error bit.
  - Reset asserted mid-CONV or mid-DONE: immediate return to reset values. The partial word is discarded and nothing is emitted.
  - out_err = |err_mask, registered together with the mask.

Test Plan:
- Normal conversion: reset, DIGITS=4, BCD_CHECK=1, in_data=16'h1234 with in_valid for one cycle.
  - Required: out_valid high 4 cycles after accept, out_data=16'h4567, err_mask=4'b0000, out_err=0.
- Strict-mode errors: in_data=16'h9A05 with BCD_CHECK=1.
  - Required: out_data=16'hC038, err_mask=4'b0100, out_err=1.
- Range mode: same stimulus with BCD_CHECK=0 → out_data=16'hCD38, err_mask=0. Then in_data=16'hF0E0 → out_data=16'h0303, err_mask=4'b1010.
- Backpressure: hold out_ready=0 for 6 cycles in DONE, and pulse in_valid with 16'h7777 meanwhile.
  - Required: out_valid and out_data=16'h4567 stable throughout, in_ready=0, 16'h7777 not captured.
  - After out_ready=1: IDLE, in_ready=1.
- Reset mid-operation: assert rst_n=0 in the 2nd CONV cycle of 16'h1234.
  - Required: all outputs go to reset values asynchronously.
  - After release, a fresh 16'h0000 yields out_data=16'h3333 with no stale digits.
- Streaming: 3 words with in_valid and out_ready held high.
  - Required: accepts spaced exactly 6 cycles apart, each output correct in order.

Source files
------------

// File: rtl/xs3_digit_sequencer.sv
// Packed-digit to excess-3 converter: one digit per clock through a single +3 stage.
// out_valid rises DIGITS cycles after accept; result held in DONE until out_ready, no new word accepted meanwhile.
module xs3_digit_sequencer #(
  parameter int DIGITS    = 4,
  parameter bit BCD_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  out_err,
  output logic                  busy
);

  localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] cap_q, cap_d;
  logic [4*DIGITS-1:0] res_q, res_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                err_q, err_d;

  logic [3:0]          dig;
  logic [3:0]          dig_xs3;
  logic                dig_bad;

  // The one shared converter, fed by the digit the index currently points at.
  always_comb begin
    dig     = cap_q[{idx_q, 2'b00} +: 4];
    dig_bad = BCD_CHECK ? (dig > 4'd9) : (dig >= 4'd13);
    dig_xs3 = dig_bad ? 4'h0 : dig + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    res_d   = res_q;
    mask_d  = mask_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cap_d   = in_data;
          res_d   = '0;
          mask_d  = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        res_d[{idx_q, 2'b00} +: 4] = dig_xs3;
        mask_d[idx_q]              = dig_bad;
        err_d                      = |mask_d;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cap_q   <= '0;
      res_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      res_q   <= res_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs come from state alone so there is no input-to-output path.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = res_q;
  assign err_mask  = mask_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_xs3_digit_sequencer.sv
// Bench for xs3_digit_sequencer: strict and range instances share one stimulus stream,
// each with its own expected-result queue drained by a negedge monitor.
module tb_xs3_digit_sequencer;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  m;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready_s, out_valid_s, out_err_s, busy_s;
  logic [15:0] out_data_s;
  logic [3:0]  err_mask_s;
  logic        in_ready_r, out_valid_r, out_err_r, busy_r;
  logic [15:0] out_data_r;
  logic [3:0]  err_mask_r;

  exp_t exp_s[$];
  exp_t exp_r[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_edge  = 0;
  int last_acc  = 0;
  bit have_last = 0;
  bit stream_chk = 0;
  bit prev_s = 0;
  bit prev_r = 0;

  xs3_digit_sequencer #(.DIGITS(4), .BCD_CHECK(1'b1)) u_strict (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .err_mask(err_mask_s), .out_err(out_err_s), .busy(busy_s)
  );

  xs3_digit_sequencer #(.DIGITS(4), .BCD_CHECK(1'b0)) u_range (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_data(in_data), .out_valid(out_valid_r), .out_ready(out_ready),
    .out_data(out_data_r), .err_mask(err_mask_r), .out_err(out_err_r), .busy(busy_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: pops an expectation for every completed output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_s = 0;
        prev_r = 0;
      end else begin
        chk("excl_strict", in_ready_s & out_valid_s, 0);
        chk("excl_range", in_ready_r & out_valid_r, 0);
        if (in_valid && in_ready_s) begin
          acc_edge = cyc + 1;
          if (stream_chk && have_last) chk("stream_spacing", acc_edge - last_acc, 6);
          last_acc  = acc_edge;
          have_last = 1;
        end
        if (out_valid_s && !prev_s) chk("latency_strict", cyc - acc_edge, 4);
        if (out_valid_r && !prev_r) chk("latency_range", cyc - acc_edge, 4);
        if (out_valid_s && out_ready) begin
          if (exp_s.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_strict unexpected output actual=%h required=none", out_data_s);
          end else begin
            e = exp_s.pop_front();
            chk("data_strict", out_data_s, e.d);
            chk("mask_strict", err_mask_s, e.m);
            chk("err_strict", out_err_s, |e.m);
          end
        end
        if (out_valid_r && out_ready) begin
          if (exp_r.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_range unexpected output actual=%h required=none", out_data_r);
          end else begin
            e = exp_r.pop_front();
            chk("data_range", out_data_r, e.d);
            chk("mask_range", err_mask_r, e.m);
            chk("err_range", out_err_r, |e.m);
          end
        end
        prev_s = out_valid_s;
        prev_r = out_valid_r;
      end
    end
  end

  task automatic wait_rdy();
    int n = 0;
    while (!in_ready_s && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_timeout", in_ready_s, 1);
  endtask

  task automatic wait_vld();
    int n = 0;
    while (!out_valid_s && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_timeout", out_valid_s, 1);
  endtask

  task automatic send(input logic [15:0] w, input logic [15:0] ds, input logic [3:0] ms,
                      input logic [15:0] dr, input logic [3:0] mr, input bit hold);
    in_data  = w;
    in_valid = 1'b1;
    wait_rdy();
    exp_s.push_back('{d: ds, m: ms});
    exp_r.push_back('{d: dr, m: mr});
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vld_s"}, out_valid_s, 0);
    chk({tag, "_busy_s"}, busy_s, 0);
    chk({tag, "_data_s"}, out_data_s, 0);
    chk({tag, "_mask_s"}, err_mask_s, 0);
    chk({tag, "_err_s"}, out_err_s, 0);
    chk({tag, "_busy_r"}, busy_r, 0);
    chk({tag, "_data_r"}, out_data_r, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", in_ready_s, 1);

    // Directed words with hand-worked results for strict / range modes.
    send(16'h1234, 16'h4567, 4'b0000, 16'h4567, 4'b0000, 0);
    send(16'h9A05, 16'hC038, 4'b0100, 16'hCD38, 4'b0000, 0);
    send(16'hF0E0, 16'h0303, 4'b1010, 16'h0303, 4'b1010, 0);
    wait_rdy();

    // Backpressure: result must sit still while a stray word is offered.
    out_ready = 1'b0;
    send(16'h1234, 16'h4567, 4'b0000, 16'h4567, 4'b0000, 0);
    wait_vld();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        in_data  = 16'h7777;
        in_valid = 1'b1;
      end
      if (i == 3) in_valid = 1'b0;
      chk("bp_valid", out_valid_s, 1);
      chk("bp_data", out_data_s, 16'h4567);
      chk("bp_in_ready", in_ready_s, 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready_s, 1);
    chk("bp_release_valid", out_valid_s, 0);
    chk("bp_release_busy", busy_s, 0);

    // Reset during the second conversion cycle.
    send(16'h1234, 16'h4567, 4'b0000, 16'h4567, 4'b0000, 0);
    @(posedge clk); #1;
    chk("mid_busy", busy_s, 1);
    chk("mid_partial", out_data_s, 16'h0007);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    exp_s.delete();
    exp_r.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0000, 16'h3333, 4'b0000, 16'h3333, 4'b0000, 0);
    wait_rdy();

    // Streaming with both handshakes held high.
    stream_chk = 1;
    have_last  = 0;
    send(16'h1234, 16'h4567, 4'b0000, 16'h4567, 4'b0000, 1);
    send(16'h9A05, 16'hC038, 4'b0100, 16'hCD38, 4'b0000, 1);
    send(16'h0987, 16'h3CBA, 4'b0000, 16'h3CBA, 4'b0000, 0);
    wait_rdy();
    stream_chk = 0;

    for (int n = 0; n < 50 && (exp_s.size() != 0 || exp_r.size() != 0); n++) begin
      @(posedge clk); #1;
    end
    chk("drain_strict", exp_s.size(), 0);
    chk("drain_range", exp_r.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
